// File: rtl/dma_pcie_mi_dsc_cpld_ram.sv
// Descriptor completion RAM: 64-bit-lane write enables, per-byte parity stored
// alongside the data, single/double parity error flags on the read path, and
// saturating error counters.
module dma_pcie_mi_dsc_cpld_ram #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned ADR_W  = 10,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADR_W-1:0]      wadr,
  input  logic [DATA_W/64-1:0]  wen,
  input  logic [DATA_W/8-1:0]   wpar,
  input  logic [DATA_W-1:0]     wdat,
  input  logic                  ren,
  input  logic [ADR_W-1:0]      radr,
  input  logic                  inj_err,
  input  logic                  cnt_clr,
  output logic                  rvld,
  output logic [DATA_W-1:0]     rdat,
  output logic [DATA_W/8-1:0]   rpar,
  output logic                  rsbe,
  output logic                  rdbe,
  output logic [15:0]           sbe_cnt,
  output logic [15:0]           dbe_cnt
);

  localparam int unsigned LANES = DATA_W / 64;
  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned DEPTH = 1 << ADR_W;

  logic [DATA_W-1:0] mem_dat [DEPTH];
  logic [BYTES-1:0]  mem_par [DEPTH];

  logic [LANES-1:0]  low_oh;
  logic [BYTES-1:0]  wpar_eff;
  logic [DATA_W-1:0] rd_dat;
  logic [BYTES-1:0]  rd_par;
  logic              src_vld;
  logic [DATA_W-1:0] src_dat;
  logic [BYTES-1:0]  src_par;
  logic [1:0]        chk;

  // Returns {two-or-more mismatches, exactly one mismatch} for a data/parity pair.
  function automatic logic [1:0] par_chk(input logic [DATA_W-1:0] d, input logic [BYTES-1:0] p);
    logic [BYTES-1:0] mm;
    int n;
    for (int i = 0; i < int'(BYTES); i++) mm[i] = (^d[i*8 +: 8]) ^ p[i];
    n = $countones(mm);
    return {n >= 2, n == 1};
  endfunction

  // Lowest enabled lane as one-hot; injection flips its parity bit 0.
  assign low_oh = wen & (~wen + LANES'(1));

  // Parity as it will be stored, including an injected error.
  always_comb begin
    wpar_eff = wpar;
    for (int k = 0; k < int'(LANES); k++) begin
      wpar_eff[k*8] = wpar[k*8] ^ (inj_err & low_oh[k]);
    end
  end

  // Array write, lane-granular; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(LANES); k++) begin
      if (wen[k]) begin
        mem_dat[wadr][k*64 +: 64] <= wdat[k*64 +: 64];
        mem_par[wadr][k*8 +: 8]   <= wpar_eff[k*8 +: 8];
      end
    end
  end

  // Array read with optional same-address forwarding of the written lanes.
  always_comb begin
    rd_dat = mem_dat[radr];
    rd_par = mem_par[radr];
    if (BYPASS != 0 && wadr == radr) begin
      for (int k = 0; k < int'(LANES); k++) begin
        if (wen[k]) begin
          rd_dat[k*64 +: 64] = wdat[k*64 +: 64];
          rd_par[k*8 +: 8]   = wpar_eff[k*8 +: 8];
        end
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              s_vld;
      logic [DATA_W-1:0] s_dat;
      logic [BYTES-1:0]  s_par;

      // Array output register; the parity check runs on this registered data.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s_vld <= 1'b0;
          s_dat <= '0;
          s_par <= '0;
        end else begin
          s_vld <= ren;
          if (ren) begin
            s_dat <= rd_dat;
            s_par <= rd_par;
          end
        end
      end

      assign src_vld = s_vld;
      assign src_dat = s_dat;
      assign src_par = s_par;
    end else begin : g_lat1
      assign src_vld = ren;
      assign src_dat = rd_dat;
      assign src_par = rd_par;
    end
  endgenerate

  assign chk = par_chk(src_dat, src_par);

  // Output register: data, stored parity and valid-qualified error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvld <= 1'b0;
      rdat <= '0;
      rpar <= '0;
      rsbe <= 1'b0;
      rdbe <= 1'b0;
    end else begin
      rvld <= src_vld;
      rsbe <= src_vld & chk[0];
      rdbe <= src_vld & chk[1];
      if (src_vld) begin
        rdat <= src_dat;
        rpar <= src_par;
      end
    end
  end

  // Saturating error counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sbe_cnt <= '0;
      dbe_cnt <= '0;
    end else if (cnt_clr) begin
      sbe_cnt <= '0;
      dbe_cnt <= '0;
    end else begin
      if (rsbe && sbe_cnt != 16'hFFFF) sbe_cnt <= sbe_cnt + 16'd1;
      if (rdbe && dbe_cnt != 16'hFFFF) dbe_cnt <= dbe_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_dma_pcie_mi_dsc_cpld_ram.sv
// Bench for the completion RAM: two instances share the inputs, one with
// RD_LAT=2/BYPASS=1 (a_*) and one with RD_LAT=1/BYPASS=0 (b_*), checked
// against a lane-level memory model.
module tb_dma_pcie_mi_dsc_cpld_ram;

  localparam int unsigned DW = 512;
  localparam int unsigned AW = 10;
  localparam int unsigned NB = DW / 8;
  localparam int unsigned NL = DW / 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] wadr, radr;
  logic [NL-1:0] wen;
  logic [NB-1:0] wpar;
  logic [DW-1:0] wdat;
  logic          ren, inj_err, cnt_clr;

  logic          a_rvld, a_rsbe, a_rdbe, b_rvld, b_rsbe, b_rdbe;
  logic [DW-1:0] a_rdat, b_rdat;
  logic [NB-1:0] a_rpar, b_rpar;
  logic [15:0]   a_sbe, a_dbe, b_sbe, b_dbe;

  logic [DW-1:0] m_dat [1 << AW];
  logic [NB-1:0] m_par [1 << AW];

  int tests = 0;
  int fails = 0;

  dma_pcie_mi_dsc_cpld_ram #(.DATA_W(DW), .ADR_W(AW), .RD_LAT(2), .BYPASS(1)) u_a (
    .clk(clk), .rst(rst), .wadr(wadr), .wen(wen), .wpar(wpar), .wdat(wdat),
    .ren(ren), .radr(radr), .inj_err(inj_err), .cnt_clr(cnt_clr),
    .rvld(a_rvld), .rdat(a_rdat), .rpar(a_rpar), .rsbe(a_rsbe), .rdbe(a_rdbe),
    .sbe_cnt(a_sbe), .dbe_cnt(a_dbe));

  dma_pcie_mi_dsc_cpld_ram #(.DATA_W(DW), .ADR_W(AW), .RD_LAT(1), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .wadr(wadr), .wen(wen), .wpar(wpar), .wdat(wdat),
    .ren(ren), .radr(radr), .inj_err(inj_err), .cnt_clr(cnt_clr),
    .rvld(b_rvld), .rdat(b_rdat), .rpar(b_rpar), .rsbe(b_rsbe), .rdbe(b_rdbe),
    .sbe_cnt(b_sbe), .dbe_cnt(b_dbe));

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rnd_dat();
    logic [DW-1:0] r;
    for (int i = 0; i < int'(DW / 32); i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [NB-1:0] par_of(input logic [DW-1:0] d);
    logic [NB-1:0] p;
    for (int i = 0; i < int'(NB); i++) p[i] = ^d[i*8 +: 8];
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Deasserted enables with random junk on the address/data/parity inputs.
  task automatic idle();
    wen     = '0;
    ren     = 1'b0;
    inj_err = 1'b0;
    cnt_clr = 1'b0;
    wadr    = AW'($urandom);
    radr    = AW'($urandom);
    wdat    = rnd_dat();
    wpar    = {$urandom, $urandom};
  endtask

  // Drives a write and updates the model as it will look after the next edge.
  task automatic wr(input logic [AW-1:0] a, input logic [NL-1:0] en,
                    input logic [DW-1:0] d, input logic [NB-1:0] p, input logic inj);
    bit done;
    done    = 1'b0;
    wadr    = a;
    wen     = en;
    wdat    = d;
    wpar    = p;
    inj_err = inj;
    for (int k = 0; k < int'(NL); k++) begin
      if (en[k]) begin
        m_dat[a][k*64 +: 64] = d[k*64 +: 64];
        m_par[a][k*8 +: 8]   = p[k*8 +: 8];
        if (inj && !done) begin
          m_par[a][k*8] = ~m_par[a][k*8];
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic rd(input logic [AW-1:0] a);
    ren  = 1'b1;
    radr = a;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    repeat (3) tick();
    tests++;
    if ({a_rvld, a_rsbe, a_rdbe, b_rvld, b_rsbe, b_rdbe} !== 6'b0) begin
      fails++; $display("FAIL reset_flags a=%b%b%b b=%b%b%b expected 000 000", a_rvld, a_rsbe, a_rdbe, b_rvld, b_rsbe, b_rdbe);
    end
    tests++;
    if (a_rdat !== '0 || b_rdat !== '0 || a_rpar !== '0 || b_rpar !== '0) begin
      fails++; $display("FAIL reset_data a_rdat=%h b_rdat=%h expected 0", a_rdat, b_rdat);
    end
    tests++;
    if (a_sbe !== 16'h0 || a_dbe !== 16'h0 || b_sbe !== 16'h0 || b_dbe !== 16'h0) begin
      fails++; $display("FAIL reset_cnt a=%h/%h b=%h/%h expected 0", a_sbe, a_dbe, b_sbe, b_dbe);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [DW-1:0] a;
    a = rnd_dat();
    idle(); wr(AW'(5), 8'hFF, a, par_of(a), 1'b0); tick();
    idle(); tick();
    idle(); rd(AW'(5)); tick();
    tests++;
    if (b_rvld !== 1'b1 || b_rdat !== a) begin
      fails++; $display("FAIL basic_lat1 rvld=%b rdat=%h expected 1 %h", b_rvld, b_rdat, a);
    end
    tests++;
    if (a_rvld !== 1'b0) begin
      fails++; $display("FAIL basic_lat2_early rvld=%b expected 0", a_rvld);
    end
    idle(); tick();
    tests++;
    if (a_rvld !== 1'b1 || a_rdat !== a || a_rpar !== par_of(a)) begin
      fails++; $display("FAIL basic_lat2 rvld=%b rdat=%h expected 1 %h", a_rvld, a_rdat, a);
    end
    tests++;
    if (a_rsbe !== 1'b0 || a_rdbe !== 1'b0 || b_rvld !== 1'b0) begin
      fails++; $display("FAIL basic_flags rsbe=%b rdbe=%b b_rvld=%b expected 0 0 0", a_rsbe, a_rdbe, b_rvld);
    end
  endtask

  task automatic test_bypass();
    logic [AW-1:0] ad;
    logic [NL-1:0] mask;
    logic [DW-1:0] od, nd, ed, f;
    logic [NB-1:0] op, np, ep;
    for (int i = 0; i < 3; i++) begin
      ad   = (i == 0) ? AW'(5) : AW'($urandom_range(100, 199));
      mask = (i == 0) ? 8'h01 : NL'($urandom_range(1, 255));
      if (i != 0) begin
        f = rnd_dat();
        idle(); wr(ad, 8'hFF, f, par_of(f), 1'b0); tick();
      end
      od = m_dat[ad]; op = m_par[ad];
      nd = rnd_dat(); np = par_of(nd);
      ed = od; ep = op;
      for (int k = 0; k < int'(NL); k++) begin
        if (mask[k]) begin
          ed[k*64 +: 64] = nd[k*64 +: 64];
          ep[k*8 +: 8]   = np[k*8 +: 8];
        end
      end
      idle(); wr(ad, mask, nd, np, 1'b0); rd(ad); tick();
      tests++;
      if (b_rvld !== 1'b1 || b_rdat !== od || b_rpar !== op) begin
        fails++; $display("FAIL bypass_old[%0d] rdat=%h expected %h", i, b_rdat, od);
      end
      idle(); tick();
      tests++;
      if (a_rvld !== 1'b1 || a_rdat !== ed || a_rpar !== ep || a_rsbe !== 1'b0) begin
        fails++; $display("FAIL bypass_new[%0d] rdat=%h expected %h", i, a_rdat, ed);
      end
      idle(); rd(ad); tick();
      tests++;
      if (b_rdat !== ed) begin
        fails++; $display("FAIL bypass_after[%0d] rdat=%h expected %h", i, b_rdat, ed);
      end
      idle(); tick();
    end
  endtask

  task automatic test_errors();
    logic [DW-1:0] d, d2, d3;
    idle(); cnt_clr = 1'b1; tick();
    idle(); tick();
    d = rnd_dat(); idle(); wr(AW'(9), 8'hFF, d, par_of(d), 1'b0); tick();
    d2 = rnd_dat(); idle(); wr(AW'(9), 8'h0C, d2, par_of(d2), 1'b1); tick();
    idle(); rd(AW'(9)); tick();
    tests++;
    if (b_rsbe !== 1'b1 || b_rdbe !== 1'b0) begin
      fails++; $display("FAIL inj_lat1 rsbe=%b rdbe=%b expected 1 0", b_rsbe, b_rdbe);
    end
    idle(); tick();
    tests++;
    if (a_rsbe !== 1'b1 || a_rdbe !== 1'b0 || a_rpar !== (par_of(m_dat[9]) ^ 64'h1_0000) || a_rdat !== m_dat[9]) begin
      fails++; $display("FAIL inj_lat2 rsbe=%b rdbe=%b rpar=%h expected 1 0 %h", a_rsbe, a_rdbe, a_rpar, par_of(m_dat[9]) ^ 64'h1_0000);
    end
    tick(); tick();
    tests++;
    if (a_sbe !== 16'd1 || b_sbe !== 16'd1 || a_dbe !== 16'd0 || b_dbe !== 16'd0) begin
      fails++; $display("FAIL inj_cnt sbe a=%0d b=%0d dbe a=%0d b=%0d expected 1 1 0 0", a_sbe, b_sbe, a_dbe, b_dbe);
    end
    d3 = rnd_dat(); idle(); wr(AW'(9), 8'hFF, d3, par_of(d3) ^ 64'h201, 1'b0); tick();
    idle(); rd(AW'(9)); tick();
    tests++;
    if (b_rdbe !== 1'b1 || b_rsbe !== 1'b0) begin
      fails++; $display("FAIL dbe_lat1 rsbe=%b rdbe=%b expected 0 1", b_rsbe, b_rdbe);
    end
    idle(); tick();
    tests++;
    if (a_rdbe !== 1'b1 || a_rsbe !== 1'b0) begin
      fails++; $display("FAIL dbe_lat2 rsbe=%b rdbe=%b expected 0 1", a_rsbe, a_rdbe);
    end
    tick(); tick();
    tests++;
    if (a_dbe !== 16'd1 || b_dbe !== 16'd1 || a_sbe !== 16'd1 || b_sbe !== 16'd1) begin
      fails++; $display("FAIL dbe_cnt dbe a=%0d b=%0d sbe a=%0d b=%0d expected 1 1 1 1", a_dbe, b_dbe, a_sbe, b_sbe);
    end
    d = rnd_dat(); idle(); wr(AW'(11), 8'hFF, d, par_of(d), 1'b0); tick();
    idle(); wadr = AW'(11); inj_err = 1'b1; tick();
    idle(); rd(AW'(11)); tick();
    idle(); tick();
    tests++;
    if (a_rsbe !== 1'b0 || a_rdbe !== 1'b0 || a_rdat !== d || a_rpar !== par_of(d)) begin
      fails++; $display("FAIL inj_nowrite rsbe=%b rdbe=%b rpar=%h expected 0 0 %h", a_rsbe, a_rdbe, a_rpar, par_of(d));
    end
    tick(); tick();
    tests++;
    if (a_sbe !== 16'd1 || b_sbe !== 16'd1) begin
      fails++; $display("FAIL inj_nowrite_cnt sbe a=%0d b=%0d expected 1 1", a_sbe, b_sbe);
    end
  endtask

  task automatic test_saturate();
    logic [DW-1:0] d;
    d = rnd_dat();
    idle(); wr(AW'(12), 8'hFF, d, par_of(d), 1'b0); tick();
    idle(); wr(AW'(12), 8'h01, d, par_of(d), 1'b1); tick();
    idle(); cnt_clr = 1'b1; tick();
    idle(); rd(AW'(12));
    repeat (65534) tick();
    idle(); repeat (3) tick();
    tests++;
    if (a_sbe !== 16'hFFFE || b_sbe !== 16'hFFFE) begin
      fails++; $display("FAIL sat_preload sbe a=%h b=%h expected fffe", a_sbe, b_sbe);
    end
    rd(AW'(12)); repeat (3) tick();
    idle(); repeat (3) tick();
    tests++;
    if (a_sbe !== 16'hFFFF || b_sbe !== 16'hFFFF || a_dbe !== 16'h0) begin
      fails++; $display("FAIL sat_hold sbe a=%h b=%h dbe a=%h expected ffff ffff 0", a_sbe, b_sbe, a_dbe);
    end
    idle(); rd(AW'(12)); tick();
    tests++;
    if (b_rsbe !== 1'b1) begin
      fails++; $display("FAIL clr_setup_b rsbe=%b expected 1", b_rsbe);
    end
    idle(); cnt_clr = 1'b1; tick();
    tests++;
    if (a_rsbe !== 1'b1) begin
      fails++; $display("FAIL clr_setup_a rsbe=%b expected 1", a_rsbe);
    end
    tick();
    idle(); tick();
    tests++;
    if (a_sbe !== 16'h0 || b_sbe !== 16'h0 || a_dbe !== 16'h0 || b_dbe !== 16'h0) begin
      fails++; $display("FAIL clr_prio sbe a=%h b=%h dbe a=%h b=%h expected 0", a_sbe, b_sbe, a_dbe, b_dbe);
    end
  endtask

  task automatic test_reset_flush();
    logic [DW-1:0] d;
    int seen;
    d = rnd_dat();
    idle(); wr(AW'(20), 8'hFF, d, par_of(d), 1'b0); tick();
    idle(); rd(AW'(20)); tick();
    idle(); rst = 1'b1; #1;
    tests++;
    if (a_rvld !== 1'b0 || b_rvld !== 1'b0 || a_rdat !== '0) begin
      fails++; $display("FAIL flush_async rvld a=%b b=%b expected 0 0", a_rvld, b_rvld);
    end
    repeat (3) tick();
    rst  = 1'b0;
    seen = 0;
    repeat (6) begin
      tick();
      if (a_rvld !== 1'b0 || b_rvld !== 1'b0) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++; $display("FAIL flush_no_rvld cycles_with_rvld=%0d expected 0", seen);
    end
    idle(); rd(AW'(20)); tick();
    tests++;
    if (b_rvld !== 1'b1 || b_rdat !== d) begin
      fails++; $display("FAIL persist_lat1 rdat=%h expected %h", b_rdat, d);
    end
    idle(); tick();
    tests++;
    if (a_rvld !== 1'b1 || a_rdat !== d || a_rpar !== par_of(d)) begin
      fails++; $display("FAIL persist_lat2 rdat=%h expected %h", a_rdat, d);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 24;
    logic [AW-1:0] ad [4];
    logic [AW-1:0] seq [N];
    logic [DW-1:0] f;
    int base;
    base = int'($urandom_range(300, 900));
    for (int j = 0; j < 4; j++) begin
      ad[j] = AW'(base + j * 17);
      f = rnd_dat(); idle(); wr(ad[j], 8'hFF, f, par_of(f), 1'b0); tick();
      f = rnd_dat(); idle(); wr(ad[j], NL'($urandom), f, par_of(f), 1'b0); tick();
    end
    for (int k = 0; k < N; k++) seq[k] = ad[$urandom_range(0, 3)];
    for (int k = 0; k <= N; k++) begin
      idle();
      if (k < N) rd(seq[k]);
      tick();
      if (k < N) begin
        tests++;
        if (b_rvld !== 1'b1 || b_rdat !== m_dat[seq[k]] || b_rsbe !== 1'b0) begin
          fails++; $display("FAIL b2b_lat1[%0d] rvld=%b rdat=%h expected %h", k, b_rvld, b_rdat, m_dat[seq[k]]);
        end
      end
      if (k > 0) begin
        tests++;
        if (a_rvld !== 1'b1 || a_rdat !== m_dat[seq[k-1]] || a_rpar !== m_par[seq[k-1]]) begin
          fails++; $display("FAIL b2b_lat2[%0d] rvld=%b rdat=%h expected %h", k - 1, a_rvld, a_rdat, m_dat[seq[k-1]]);
        end
      end
    end
    idle(); tick();
    tests++;
    if (a_rvld !== 1'b0 || b_rvld !== 1'b0) begin
      fails++; $display("FAIL b2b_drain rvld a=%b b=%b expected 0 0", a_rvld, b_rvld);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_errors();
    test_saturate();
    test_reset_flush();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
